// File: rtl/alu_16bit_if.sv
// Operand/command bundle feeding alu_16bit and its registered result/flag.
// No handshake: the core takes a new command every clock and answers one clock later.
interface alu_16bit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             carry_in;
  logic             carry_disable;
  logic [2:0]       cmd;
  logic [WIDTH-1:0] res;
  logic             carry_out;

  modport master (
    output d1, d2, carry_in, carry_disable, cmd,
    input  res, carry_out
  );

  modport slave (
    input  d1, d2, carry_in, carry_disable, cmd,
    output res, carry_out
  );
endinterface

// File: rtl/alu_16bit.sv
// ALU core: carry-lookahead add/sub/compare, right shift and bitwise ops.
// Outputs are registered, so results appear one clock after the command.
module alu_16bit #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  alu_16bit_if.slave  bus
);
  localparam int NG = WIDTH / 4;

  typedef enum logic [2:0] {
    CMD_ADD   = 3'd0,
    CMD_SUB   = 3'd1,
    CMD_COMP  = 3'd2,
    CMD_RSHFT = 3'd3,
    CMD_AND   = 3'd4,
    CMD_OR    = 3'd5,
    CMD_XOR   = 3'd6,
    CMD_XNOR  = 3'd7
  } cmd_e;

  logic             cin_eff;
  logic             adder_cin;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] bit_c;
  logic [WIDTH-1:0] sum;
  logic [NG:0]      carry;
  logic [3:0]       grp;
  logic [WIDTH-1:0] res_d, res_q;
  logic             carry_d, carry_q;

  // Returns {c4, c3, c2, c1} for one 4-bit lookahead group.
  function automatic logic [3:0] cla4(input logic [3:0] gg, input logic [3:0] pp,
                                      input logic c0);
    logic c1, c2, c3, c4;
    c1 = gg[0] | (pp[0] & c0);
    c2 = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
    c3 = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & c0);
    c4 = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
       | (pp[3] & pp[2] & pp[1] & pp[0] & c0);
    return {c4, c3, c2, c1};
  endfunction

  assign cin_eff = bus.carry_in & ~bus.carry_disable;

  // SUB is d1 + ~d2 + 1 and COMP is d1 + ~d2, so both share the adder.
  always_comb begin
    op_b      = bus.d2;
    adder_cin = cin_eff;
    if (bus.cmd == CMD_SUB) begin
      op_b      = ~bus.d2;
      adder_cin = 1'b1;
    end else if (bus.cmd == CMD_COMP) begin
      op_b      = ~bus.d2;
      adder_cin = 1'b0;
    end
  end

  assign p = bus.d1 ^ op_b;
  assign g = bus.d1 & op_b;

  always_comb begin
    carry    = '0;
    bit_c    = '0;
    grp      = '0;
    carry[0] = adder_cin;
    for (int k = 0; k < NG; k++) begin
      grp              = cla4(g[4*k +: 4], p[4*k +: 4], carry[k]);
      bit_c[4*k]       = carry[k];
      bit_c[4*k+1 +: 3] = grp[2:0];
      carry[k+1]       = grp[3];
    end
  end

  assign sum = p ^ bit_c;

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    case (cmd_e'(bus.cmd))
      CMD_ADD, CMD_SUB, CMD_COMP: begin
        res_d   = sum;
        carry_d = carry[NG];
      end
      CMD_RSHFT: begin
        res_d   = {cin_eff, bus.d2[WIDTH-1:1]};
        carry_d = bus.d2[0];
      end
      CMD_AND:  res_d = bus.d1 & bus.d2;
      CMD_OR:   res_d = bus.d1 | bus.d2;
      CMD_XOR:  res_d = bus.d1 ^ bus.d2;
      CMD_XNOR: res_d = ~(bus.d1 ^ bus.d2);
      default: begin
        res_d   = '0;
        carry_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  assign bus.res       = res_q;
  assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_alu_16bit.sv
// Bench for alu_16bit: directed and random ops on a 16-bit core, exhaustive sweep on a 4-bit core.
module tb_alu_16bit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_16bit_if #(.WIDTH(16)) bus16 ();
  alu_16bit_if #(.WIDTH(4))  bus4 ();

  alu_16bit #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  alu_16bit #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  // Expected entry: {cmd[2:0], carry, res[15:0]}
  logic [19:0] exp16_q[$];
  logic [19:0] exp4_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [16:0] ref_model(input int w, input logic [2:0] cmd,
                                            input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic cdis);
    longint mask, ua, ub, ce, s, r, c;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    ce   = (cin && !cdis) ? 1 : 0;
    r    = 0;
    c    = 0;
    case (cmd)
      3'd0: begin s = ua + ub + ce; r = s & mask; c = (s >> w) & 1; end
      3'd1: begin r = (ua - ub) & mask; c = (ua >= ub) ? 1 : 0; end
      3'd2: begin r = (ua - ub - 1) & mask; c = (ua > ub) ? 1 : 0; end
      3'd3: begin r = (ub >> 1) | (ce << (w - 1)); c = ub & 1; end
      3'd4: r = ua & ub;
      3'd5: r = ua | ub;
      3'd6: r = ua ^ ub;
      default: r = ~(ua ^ ub) & mask;
    endcase
    return {c[0], r[15:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue16(input logic [2:0] cmd, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic cdis,
                         input logic [15:0] exp_res, input logic exp_c);
    @(negedge clk);
    bus16.cmd = cmd; bus16.d1 = a; bus16.d2 = b;
    bus16.carry_in = cin; bus16.carry_disable = cdis;
    exp16_q.push_back({cmd, exp_c, exp_res});
  endtask

  task automatic issue16_rand();
    logic [2:0]  cmd;
    logic [15:0] a, b;
    logic        cin, cdis;
    logic [16:0] e;
    cmd  = 3'($urandom_range(0, 7));
    a    = 16'($urandom_range(0, 65535));
    b    = 16'($urandom_range(0, 65535));
    cin  = 1'($urandom_range(0, 1));
    cdis = 1'($urandom_range(0, 1));
    e    = ref_model(16, cmd, a, b, cin, cdis);
    issue16(cmd, a, b, cin, cdis, e[15:0], e[16]);
  endtask

  task automatic issue4(input logic [2:0] cmd, input logic [3:0] a, input logic [3:0] b,
                        input logic cin, input logic cdis);
    logic [16:0] e;
    e = ref_model(4, cmd, {12'd0, a}, {12'd0, b}, cin, cdis);
    @(negedge clk);
    bus4.cmd = cmd; bus4.d1 = a; bus4.d2 = b;
    bus4.carry_in = cin; bus4.carry_disable = cdis;
    exp4_q.push_back({cmd, e[16], e[15:0]});
  endtask

  task automatic check_direct(input string name, input logic [15:0] got_res, input logic got_c,
                              input logic [15:0] exp_res, input logic exp_c);
    checks++;
    if (got_res !== exp_res || got_c !== exp_c) begin
      errors++;
      $display("FAIL %s: got res=%h carry=%b, expected res=%h carry=%b",
               name, got_res, got_c, exp_res, exp_c);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(posedge clk) begin
    logic [19:0] e;
    #1;
    if (exp16_q.size() > 0) begin
      e = exp16_q.pop_front();
      checks++;
      if (bus16.res !== e[15:0] || bus16.carry_out !== e[16]) begin
        errors++;
        $display("FAIL w16 cmd=%0d: got res=%h carry=%b, expected res=%h carry=%b",
                 e[19:17], bus16.res, bus16.carry_out, e[15:0], e[16]);
      end
    end
  end

  always @(posedge clk) begin
    logic [19:0] e;
    #1;
    if (exp4_q.size() > 0) begin
      e = exp4_q.pop_front();
      checks++;
      if ({12'd0, bus4.res} !== e[15:0] || bus4.carry_out !== e[16]) begin
        errors++;
        $display("FAIL w4 cmd=%0d: got res=%h carry=%b, expected res=%h carry=%b",
                 e[19:17], bus4.res, bus4.carry_out, e[15:0], e[16]);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus16.cmd = 3'd0; bus16.d1 = '0; bus16.d2 = '0; bus16.carry_in = 1'b0; bus16.carry_disable = 1'b0;
    bus4.cmd  = 3'd0; bus4.d1  = '0; bus4.d2  = '0; bus4.carry_in  = 1'b0; bus4.carry_disable  = 1'b0;
    #1;
    check_direct("reset16", bus16.res, bus16.carry_out, 16'h0000, 1'b0);
    check_direct("reset4", {12'd0, bus4.res}, bus4.carry_out, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    issue16(3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    issue16(3'd0, 16'h0010, 16'h0020, 1'b1, 1'b0, 16'h0031, 1'b0);
    issue16(3'd0, 16'h0010, 16'h0020, 1'b1, 1'b1, 16'h0030, 1'b0);
    issue16(3'd1, 16'h0005, 16'h0007, 1'b0, 1'b0, 16'hFFFE, 1'b0);
    issue16(3'd1, 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0);
    issue16(3'd1, 16'h0007, 16'h0007, 1'b0, 1'b0, 16'h0000, 1'b1);
    issue16(3'd2, 16'h0007, 16'h0007, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    issue16(3'd2, 16'h0008, 16'h0007, 1'b1, 1'b0, 16'h0000, 1'b1);
    issue16(3'd3, 16'h1234, 16'h0003, 1'b0, 1'b0, 16'h0001, 1'b1);
    issue16(3'd3, 16'h1234, 16'h0003, 1'b1, 1'b0, 16'h8001, 1'b1);
    issue16(3'd3, 16'h1234, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1);
    issue16(3'd4, 16'h0F0F, 16'h00FF, 1'b1, 1'b0, 16'h000F, 1'b0);
    issue16(3'd5, 16'h0F0F, 16'h00FF, 1'b1, 1'b0, 16'h0FFF, 1'b0);
    issue16(3'd6, 16'h0F0F, 16'h00FF, 1'b1, 1'b0, 16'h0FF0, 1'b0);
    issue16(3'd7, 16'h0F0F, 16'h00FF, 1'b1, 1'b0, 16'hF00F, 1'b0);

    // Asynchronous reset in the middle of a cycle
    issue16(3'd0, 16'h1200, 16'h0034, 1'b0, 1'b0, 16'h1234, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_direct("async_rst", bus16.res, bus16.carry_out, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    check_direct("rst_hold", bus16.res, bus16.carry_out, 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    issue16(3'd6, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0);

    // Random back-to-back traffic
    for (int i = 0; i < 400; i++) issue16_rand();

    // Exhaustive sweep on the 4-bit core, command changes every cycle
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 8; c++)
          issue4(3'(c), 4'(a), 4'(b), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp16_q.size() != 0 || exp4_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending entries, expected 0/0",
               exp16_q.size(), exp4_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
